// File: rtl/relu_stream_mc_if.sv
// Stream bundle between the conv accumulator, the activation unit and the pooling stage.
//   in_vld/in_rdy/in_data/mode/clip_val : upstream beat plus its per-beat activation controls
//   out_vld/out_rdy/out_data            : activated beat toward the pooling/line-buffer stage
// slave  : the activation unit's view (consumes in_*, produces out_*)
// master : the surrounding environment's view (produces in_*, consumes out_*)
interface relu_stream_mc_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNELS   = 4
);
    localparam int unsigned BUS_W = DATA_WIDTH * CHANNELS;

    logic                  in_vld;
    logic                  in_rdy;
    logic [BUS_W-1:0]      in_data;
    logic [1:0]            mode;
    logic [DATA_WIDTH-1:0] clip_val;
    logic                  out_vld;
    logic                  out_rdy;
    logic [BUS_W-1:0]      out_data;

    modport slave (
        input  in_vld,
        output in_rdy,
        input  in_data,
        input  mode,
        input  clip_val,
        output out_vld,
        input  out_rdy,
        output out_data
    );

    modport master (
        output in_vld,
        input  in_rdy,
        output in_data,
        output mode,
        output clip_val,
        input  out_vld,
        output out_rdy,
        input  out_data
    );
endinterface

// File: rtl/relu_stream_mc.sv
// Multi-channel streaming activation unit (bypass / ReLU / leaky ReLU / clipped ReLU)
// applied per beat to CHANNELS signed lanes, in a 2-stage valid/ready pipeline with
// full backpressure and a saturating count of zero-valued output lanes.
// Ports:
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset, drops in-flight beats
//   bus      : stream bundle (slave view): in_vld/in_rdy/in_data/mode/clip_val, out_vld/out_rdy/out_data
//   clr_cnt  : synchronous clear of zero_cnt, wins over a simultaneous transfer
//   zero_cnt : number of zero lanes delivered downstream, saturating
module relu_stream_mc #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned LEAK_SHIFT = 3,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    relu_stream_mc_if.slave      bus,
    input  logic                 clr_cnt,
    output logic [CNT_WIDTH-1:0] zero_cnt
);
    localparam int unsigned BUS_W = DATA_WIDTH * CHANNELS;
    localparam int unsigned NZ_W  = $clog2(CHANNELS + 1);
    localparam int unsigned SUM_W = CNT_WIDTH + NZ_W;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_RELU   = 2'b01,
        MODE_LEAKY  = 2'b10,
        MODE_CLIP   = 2'b11
    } act_mode_e;

    logic                         s1_vld;
    logic [BUS_W-1:0]             s1_data;
    act_mode_e                    s1_mode;
    logic signed [DATA_WIDTH-1:0] s1_clip;
    logic                         s2_vld;
    logic [BUS_W-1:0]             s2_data;

    logic                         stall;
    logic                         s1_adv;
    logic                         in_fire;
    logic                         out_fire;
    logic [BUS_W-1:0]             act_data;
    logic [NZ_W-1:0]              nz_cnt;
    logic [SUM_W-1:0]             cnt_sum;

    // Per-lane activation; sign bit and zero test avoid mixed signed/unsigned compares.
    function automatic logic signed [DATA_WIDTH-1:0] lane_act(
        input logic signed [DATA_WIDTH-1:0] x,
        input act_mode_e                    m,
        input logic signed [DATA_WIDTH-1:0] clip
    );
        logic signed [DATA_WIDTH-1:0] y;
        logic                         x_neg;
        logic                         x_zero;
        logic                         clip_nonpos;
        x_neg       = x[DATA_WIDTH-1];
        x_zero      = (x == '0);
        clip_nonpos = clip[DATA_WIDTH-1] | (clip == '0);
        y           = x;
        case (m)
            MODE_BYPASS: y = x;
            MODE_RELU:   y = (x_neg | x_zero) ? '0 : x;
            // Arithmetic shift rounds toward -inf, so -1 stays -1.
            MODE_LEAKY:  y = x_neg ? (x >>> LEAK_SHIFT) : x;
            MODE_CLIP: begin
                if (x_neg | x_zero | clip_nonpos) begin
                    y = '0;
                end else if (x > clip) begin
                    y = clip;
                end else begin
                    y = x;
                end
            end
            default:     y = x;
        endcase
        return y;
    endfunction

    // Flow control: S2 holds while downstream stalls; S1 may still fill if empty.
    assign stall        = s2_vld & ~bus.out_rdy;
    assign s1_adv       = s1_vld & ~stall;
    assign bus.in_rdy   = ~s1_vld | ~stall;
    assign in_fire      = bus.in_vld & bus.in_rdy;
    assign out_fire     = s2_vld & bus.out_rdy;
    assign bus.out_vld  = s2_vld;
    assign bus.out_data = s2_data;

    // Stage 1: capture beat together with its own mode and clip ceiling.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s1_mode <= MODE_BYPASS;
            s1_clip <= '0;
        end else if (in_fire) begin
            s1_vld  <= 1'b1;
            s1_data <= bus.in_data;
            s1_mode <= act_mode_e'(bus.mode);
            s1_clip <= bus.clip_val;
        end else if (s1_adv) begin
            s1_vld  <= 1'b0;
        end
    end

    // Activation across all lanes of the stage-1 beat.
    always_comb begin
        act_data = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            act_data[i*DATA_WIDTH +: DATA_WIDTH] =
                lane_act(s1_data[i*DATA_WIDTH +: DATA_WIDTH], s1_mode, s1_clip);
        end
    end

    // Stage 2: output register; frozen while stalled so out_* stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_data <= '0;
        end else if (!stall) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_data <= act_data;
            end
        end
    end

    // Number of zero lanes in the beat currently presented downstream.
    always_comb begin
        nz_cnt = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (s2_data[i*DATA_WIDTH +: DATA_WIDTH] == '0) begin
                nz_cnt = nz_cnt + NZ_W'(1);
            end
        end
    end

    assign cnt_sum = SUM_W'(zero_cnt) + SUM_W'(nz_cnt);

    // Sparsity counter: clear has priority, otherwise saturating add per transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_cnt <= '0;
        end else if (clr_cnt) begin
            zero_cnt <= '0;
        end else if (out_fire) begin
            zero_cnt <= (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(cnt_sum);
        end
    end
endmodule

// File: tb/tb_relu_stream_mc.sv
// Directed bench for relu_stream_mc: activation modes, latency, backpressure,
// per-beat mode switching, counter saturation/clear and reset during a stall.
module tb_relu_stream_mc;
    logic       clk;
    logic       rst;
    logic       clr_cnt;
    logic [3:0] zero_cnt;

    int n_cmp;
    int n_bad;

    relu_stream_mc_if #(.DATA_WIDTH(8), .CHANNELS(4)) bus ();

    relu_stream_mc #(
        .DATA_WIDTH(8),
        .CHANNELS  (4),
        .LEAK_SHIFT(3),
        .CNT_WIDTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .clr_cnt (clr_cnt),
        .zero_cnt(zero_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Lane 0 in the low byte.
    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat with out_rdy high: checks acceptance, 2-cycle latency and result.
    task automatic send_beat(input string tag, input logic [1:0] m, input int clip,
                             input logic [31:0] d, input logic [31:0] exp);
        bus.out_rdy  = 1'b1;
        bus.mode     = m;
        bus.clip_val = 8'(clip);
        bus.in_data  = d;
        bus.in_vld   = 1'b1;
        #1;
        chk({tag, "_in_rdy"}, 32'(bus.in_rdy), 32'd1);
        step();
        bus.in_vld = 1'b0;
        chk({tag, "_lat1"}, 32'(bus.out_vld), 32'd0);
        step();
        chk({tag, "_vld"}, 32'(bus.out_vld), 32'd1);
        chk({tag, "_data"}, bus.out_data, exp);
        step();
        chk({tag, "_done"}, 32'(bus.out_vld), 32'd0);
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] held;
    bit          holding;
    int          sent;
    int          recv;

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst          = 1'b1;
        clr_cnt      = 1'b0;
        bus.in_vld   = 1'b0;
        bus.in_data  = '0;
        bus.mode     = 2'b00;
        bus.clip_val = '0;
        bus.out_rdy  = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_zero_cnt", 32'(zero_cnt), 32'd0);
        chk("rst_in_rdy", 32'(bus.in_rdy), 32'd1);

        // ReLU
        send_beat("relu", 2'b01, 0, pk(-5, 0, 7, -128), pk(0, 0, 7, 0));
        chk("relu_cnt", 32'(zero_cnt), 32'd3);

        // Leaky, shift 3
        send_beat("leaky", 2'b10, 0, pk(-16, -1, 127, -128), pk(-2, -1, 127, -16));
        chk("leaky_cnt", 32'(zero_cnt), 32'd3);

        // Clipped, positive and non-positive ceilings
        send_beat("clip6", 2'b11, 6, pk(10, -3, 6, 5), pk(6, 0, 6, 5));
        chk("clip6_cnt", 32'(zero_cnt), 32'd4);
        send_beat("clipn1", 2'b11, -1, pk(10, -3, 6, 5), pk(0, 0, 0, 0));
        chk("clipn1_cnt", 32'(zero_cnt), 32'd8);

        // Back-to-back beats with alternating modes on identical data
        bus.out_rdy = 1'b1;
        bus.in_data = pk(-1, -1, -1, -1);
        bus.mode    = 2'b00;
        bus.in_vld  = 1'b1;
        step();
        bus.mode = 2'b01;
        step();
        bus.in_vld = 1'b0;
        chk("alt_byp", bus.out_data, pk(-1, -1, -1, -1));
        step();
        chk("alt_relu_vld", 32'(bus.out_vld), 32'd1);
        chk("alt_relu", bus.out_data, pk(0, 0, 0, 0));
        step();
        chk("alt_cnt", 32'(zero_cnt), 32'd12);

        // 12 + 4 saturates at 15, and stays there
        send_beat("sat1", 2'b01, 0, pk(-1, -2, -3, 0), pk(0, 0, 0, 0));
        chk("sat1_cnt", 32'(zero_cnt), 32'd15);
        send_beat("sat2", 2'b00, 0, pk(0, 1, 0, 2), pk(0, 1, 0, 2));
        chk("sat2_cnt", 32'(zero_cnt), 32'd15);

        // Clear coincident with an output transfer
        bus.mode    = 2'b01;
        bus.in_data = pk(-9, -9, -9, -9);
        bus.in_vld  = 1'b1;
        step();
        bus.in_vld = 1'b0;
        step();
        chk("clr_xfer_vld", 32'(bus.out_vld), 32'd1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("clr_xfer_cnt", 32'(zero_cnt), 32'd0);

        // 10-beat ramp stream, downstream stalls in cycles 3..7
        for (int k = 0; k < 10; k++) exp_q.push_back(pk(k, k + 16, k + 32, k + 48));
        sent    = 0;
        recv    = 0;
        holding = 1'b0;
        held    = '0;
        bus.mode = 2'b00;
        for (int c = 0; c < 60 && recv < 10; c++) begin
            bus.out_rdy = !(c >= 3 && c <= 7);
            bus.in_vld  = (sent < 10);
            bus.in_data = pk(sent, sent + 16, sent + 32, sent + 48);
            #1;
            if (c == 5) chk("stall_in_rdy", 32'(bus.in_rdy), 32'd0);
            if (holding) chk("stall_hold", bus.out_data, held);
            if (bus.out_vld && bus.out_rdy) begin
                chk("stream_order", bus.out_data, exp_q[recv]);
                recv++;
            end
            holding = bus.out_vld && !bus.out_rdy;
            held    = bus.out_data;
            if (bus.in_vld && bus.in_rdy) sent++;
            step();
        end
        bus.in_vld = 1'b0;
        chk("stream_count", 32'(recv), 32'd10);
        step();
        chk("stream_drained", 32'(bus.out_vld), 32'd0);
        // Only beat 0 carried a zero lane
        chk("stream_cnt", 32'(zero_cnt), 32'd1);

        // Reset while the pipe is full and stalled
        bus.out_rdy = 1'b0;
        bus.mode    = 2'b00;
        bus.in_data = pk(1, 2, 3, 4);
        bus.in_vld  = 1'b1;
        step();
        bus.in_data = pk(5, 6, 7, 8);
        step();
        bus.in_vld = 1'b0;
        #1;
        chk("full_out_vld", 32'(bus.out_vld), 32'd1);
        chk("full_in_rdy", 32'(bus.in_rdy), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rststall_vld", 32'(bus.out_vld), 32'd0);
        chk("rststall_data", bus.out_data, 32'd0);
        chk("rststall_in_rdy", 32'(bus.in_rdy), 32'd1);
        chk("rststall_cnt", 32'(zero_cnt), 32'd0);
        bus.out_rdy = 1'b1;
        step();
        step();
        chk("rststall_empty", 32'(bus.out_vld), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
